// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and 32/32 divide (restoring),
// one iteration per clock, 32 iterations per operation.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | no operation; samples start requests and captures operands
// S_MULT   | Booth multiply iterating, counter 0..31
// S_DIV    | restoring divide on magnitudes iterating, counter 0..31
// S_FINISH | result presented; done (and div_zero) pulse for this cycle
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MULT   = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [32:0] r_m;
    logic [32:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic        r_q_m1;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_div_zero;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_booth_sum;
    logic [32:0] w_mul_hi_nxt;
    logic [31:0] w_mul_lo_nxt;
    logic [32:0] w_rem_shift;
    logic        w_ge;
    logic [31:0] w_rem_sub;
    logic [31:0] w_div_rem_nxt;
    logic [31:0] w_div_quo_nxt;
    logic [31:0] w_quo_final;
    logic [31:0] w_rem_final;

    // Magnitudes as unsigned: 0x80000000 stays 0x80000000, which is exactly 2^31.
    assign w_a_mag = a[31] ? (32'd0 - a) : a;
    assign w_b_mag = b[31] ? (32'd0 - b) : b;

    // Upper accumulator is 33 bits so that subtracting -2^31 cannot overflow.
    always_comb begin
        w_booth_sum = r_acc_hi;
        case ({r_acc_lo[0], r_q_m1})
            2'b01:   w_booth_sum = r_acc_hi + r_m;
            2'b10:   w_booth_sum = r_acc_hi - r_m;
            default: w_booth_sum = r_acc_hi;
        endcase
    end

    assign w_mul_hi_nxt = {w_booth_sum[32], w_booth_sum[32:1]};
    assign w_mul_lo_nxt = {w_booth_sum[0], r_acc_lo[31:1]};

    // Divide reuses the accumulator: r_acc_hi[31:0] is the remainder, r_acc_lo the
    // dividend shifting out / quotient shifting in, r_m[31:0] the divisor magnitude.
    assign w_rem_shift   = {r_acc_hi[31:0], r_acc_lo[31]};
    assign w_ge          = (w_rem_shift >= {1'b0, r_m[31:0]});
    assign w_rem_sub     = w_rem_shift[31:0] - r_m[31:0];
    assign w_div_rem_nxt = w_ge ? w_rem_sub : w_rem_shift[31:0];
    assign w_div_quo_nxt = {r_acc_lo[30:0], w_ge};
    assign w_quo_final   = r_neg_q ? (32'd0 - w_div_quo_nxt) : w_div_quo_nxt;
    assign w_rem_final   = r_neg_r ? (32'd0 - w_div_rem_nxt) : w_div_rem_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 5'd0;
            r_m        <= 33'd0;
            r_acc_hi   <= 33'd0;
            r_acc_lo   <= 32'd0;
            r_q_m1     <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done     <= 1'b0;
                    r_div_zero <= 1'b0;
                    if (mult_start) begin
                        r_m      <= {a[31], a};
                        r_acc_hi <= 33'd0;
                        r_acc_lo <= b;
                        r_q_m1   <= 1'b0;
                        r_cnt    <= 5'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_MULT;
                    end else if (div_start) begin
                        if (b == 32'd0) begin
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                            r_state    <= S_FINISH;
                        end else begin
                            r_m      <= {1'b0, w_b_mag};
                            r_acc_hi <= 33'd0;
                            r_acc_lo <= w_a_mag;
                            r_neg_q  <= a[31] ^ b[31];
                            r_neg_r  <= a[31];
                            r_cnt    <= 5'd0;
                            r_busy   <= 1'b1;
                            r_state  <= S_DIV;
                        end
                    end
                end
                S_MULT: begin
                    r_acc_hi <= w_mul_hi_nxt;
                    r_acc_lo <= w_mul_lo_nxt;
                    r_q_m1   <= r_acc_lo[0];
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_hi    <= w_mul_hi_nxt[31:0];
                        r_lo    <= w_mul_lo_nxt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_DIV: begin
                    r_acc_hi <= {1'b0, w_div_rem_nxt};
                    r_acc_lo <= w_div_quo_nxt;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_hi    <= w_rem_final;
                        r_lo    <= w_quo_final;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done     <= 1'b0;
                    r_div_zero <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: multiply, divide, divide by zero,
// start arbitration, mid-operation reset and restart right after FINISH.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    mult_div_unit dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one start pulse and returns at the falling edge where done is seen
    // (or after the cycle budget). nbusy counts falling edges that saw busy=1.
    task automatic do_op(input logic m, input logic d, input logic [31:0] av,
                         input logic [31:0] bv, output int nbusy, output logic seen);
        @(negedge clk);
        a = av; b = bv; mult_start = m; div_start = d;
        @(negedge clk);
        mult_start = 1'b0; div_start = 1'b0;
        nbusy = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mult_start = 1'b0; div_start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if (hi !== 32'd0)    begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd0)    begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)   begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
        reset = 1'b0;
    endtask

    task automatic test_mult();
        logic [31:0] va [5] = '{32'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] vb [5] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        logic [31:0] eh [5] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h3FFF_FFFF, 32'h0, 32'hC000_0000};
        logic [31:0] el [5] = '{32'hFFFF_FFEB, 32'h0, 32'h0000_0001, 32'h1, 32'h8000_0000};
        int nb; logic seen;
        for (int i = 0; i < 5; i++) begin
            do_op(1'b1, 1'b0, va[i], vb[i], nb, seen);
            checks++; if (!seen)   begin failures++; $display("FAIL mult_done[%0d] got=timeout exp=done", i); end
            checks++; if (nb != 32) begin failures++; $display("FAIL mult_busy_cycles[%0d] got=%0d exp=32", i, nb); end
            checks++; if (hi !== eh[i]) begin failures++; $display("FAIL mult_hi[%0d] got=%h exp=%h", i, hi, eh[i]); end
            checks++; if (lo !== el[i]) begin failures++; $display("FAIL mult_lo[%0d] got=%h exp=%h", i, lo, el[i]); end
            checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL mult_dz[%0d] got=%b exp=0", i, div_zero); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL mult_done_width[%0d] got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_div();
        logic [31:0] va [6] = '{32'hFFFF_FFF9, 32'd7, 32'd100, 32'hFFFF_FF9C, 32'h8000_0000, 32'd5};
        logic [31:0] vb [6] = '{32'd2, 32'hFFFF_FFFE, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd10};
        logic [31:0] el [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd14, 32'd14, 32'h8000_0000, 32'd0};
        logic [31:0] eh [6] = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd5};
        int nb; logic seen;
        for (int i = 0; i < 6; i++) begin
            do_op(1'b0, 1'b1, va[i], vb[i], nb, seen);
            checks++; if (!seen)   begin failures++; $display("FAIL div_done[%0d] got=timeout exp=done", i); end
            checks++; if (nb != 32) begin failures++; $display("FAIL div_busy_cycles[%0d] got=%0d exp=32", i, nb); end
            checks++; if (lo !== el[i]) begin failures++; $display("FAIL div_lo[%0d] got=%h exp=%h", i, lo, el[i]); end
            checks++; if (hi !== eh[i]) begin failures++; $display("FAIL div_hi[%0d] got=%h exp=%h", i, hi, eh[i]); end
            checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL div_dz[%0d] got=%b exp=0", i, div_zero); end
            @(negedge clk);
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL div_done_width[%0d] got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_div_zero();
        int nb; logic seen;
        do_op(1'b1, 1'b0, 32'd5, 32'd6, nb, seen);
        checks++; if (lo !== 32'd30) begin failures++; $display("FAIL dz_pre_lo got=%h exp=1e", lo); end
        do_op(1'b0, 1'b1, 32'd9, 32'd0, nb, seen);
        checks++; if (!seen)    begin failures++; $display("FAIL dz_done got=timeout exp=done"); end
        checks++; if (nb != 0)  begin failures++; $display("FAIL dz_busy_cycles got=%0d exp=0", nb); end
        checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", div_zero); end
        checks++; if (hi !== 32'd0)  begin failures++; $display("FAIL dz_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd30) begin failures++; $display("FAIL dz_lo got=%h exp=1e", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || div_zero !== 1'b0)
            begin failures++; $display("FAIL dz_pulse_width got=%b%b exp=00", done, div_zero); end
    endtask

    task automatic test_both_starts();
        int nb; logic seen;
        @(negedge clk);
        a = 32'd3; b = 32'd4; mult_start = 1'b1; div_start = 1'b1;
        @(negedge clk);
        mult_start = 1'b0; div_start = 1'b0;
        nb = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                if (nb == 10) begin
                    checks++; if (lo !== 32'd30) begin failures++; $display("FAIL both_lo_hold got=%h exp=1e", lo); end
                    a = 32'd99; b = 32'd0; mult_start = 1'b1; div_start = 1'b1;
                end else begin
                    mult_start = 1'b0; div_start = 1'b0;
                    a = 32'd3; b = 32'd4;
                end
                @(negedge clk);
            end
        end
        checks++; if (!seen)    begin failures++; $display("FAIL both_done got=timeout exp=done"); end
        checks++; if (nb != 32) begin failures++; $display("FAIL both_busy_cycles got=%0d exp=32", nb); end
        checks++; if (lo !== 32'd12) begin failures++; $display("FAIL both_lo got=%h exp=c", lo); end
        checks++; if (hi !== 32'd0)  begin failures++; $display("FAIL both_hi got=%h exp=0", hi); end
        checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL both_dz got=%b exp=0", div_zero); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0)
            begin failures++; $display("FAIL both_no_queued got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        @(negedge clk);
        a = 32'd11; b = 32'd13; mult_start = 1'b1;
        @(negedge clk);
        mult_start = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
        reset = 1'b1; mult_start = 1'b1; a = 32'd2; b = 32'd2;
        @(negedge clk);
        reset = 1'b0; mult_start = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0)
            begin failures++; $display("FAIL rmid_result got=%h_%h exp=0_0", hi, lo); end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_done) begin failures++; $display("FAIL rmid_no_activity got=active exp=idle"); end
    endtask

    task automatic test_after_reset_mult();
        int nb; logic seen;
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, nb, seen);
        checks++; if (!seen) begin failures++; $display("FAIL rmult_done got=timeout exp=done"); end
        checks++; if (hi !== 32'h4000_0000) begin failures++; $display("FAIL rmult_hi got=%h exp=40000000", hi); end
        checks++; if (lo !== 32'd0) begin failures++; $display("FAIL rmult_lo got=%h exp=0", lo); end
    endtask

    task automatic test_back_to_back();
        int nb; logic seen;
        do_op(1'b1, 1'b0, 32'd9, 32'd9, nb, seen);
        checks++; if (lo !== 32'd81) begin failures++; $display("FAIL b2b_first_lo got=%h exp=51", lo); end
        a = 32'd2; b = 32'd3; mult_start = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_finish_ignored got=%b exp=0", busy); end
        @(negedge clk);
        mult_start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_idle_accept got=%b exp=1", busy); end
        nb = 1; seen = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) nb++;
                @(negedge clk);
            end
        end
        checks++; if (nb != 32) begin failures++; $display("FAIL b2b_busy_cycles got=%0d exp=32", nb); end
        checks++; if (lo !== 32'd6 || hi !== 32'd0)
            begin failures++; $display("FAIL b2b_second got=%h_%h exp=0_6", hi, lo); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_both_starts();
        test_reset_mid();
        test_after_reset_mult();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose the following ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- mult_start  in  1  request a signed 32x32 multiply, sampled in IDLE.
- div_start  in  1  request a signed 32/32 divide, sampled in IDLE.
- a  in  32  operand A (multiplicand or dividend).
- b  in  32  operand B (multiplier or divisor).
- hi  out  32  result high word: product[63:32] or remainder.
- lo  out  32  result low word: product[31:0] or quotient.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse for the control unit.
- div_zero  out  1  one-cycle flag, coincident with done, for divide by zero.

Function
REQ-003 SHALL implement four states:
- IDLE: no operation.
- MULT: multiply in progress.
- DIV: divide in progress.
- FINISH: result presented.
REQ-004 In IDLE, a and b SHALL be captured at the same edge that samples a start request.
- mult_start=1 SHALL move to MULT.
- div_start=1 with b!=0 SHALL move to DIV.
- div_start=1 with b==0 SHALL move to FINISH.
REQ-005 If mult_start and div_start are both 1 in IDLE, multiply SHALL win and the divide request SHALL be dropped.
REQ-006 Start requests outside IDLE SHALL be ignored; they are not queued and do not affect operands.
REQ-007 MULT SHALL run radix-2 Booth on two's-complement operands.
- One iteration per cycle, driven by a 5-bit counter from 0 to 31.
- The 64-bit accumulator SHALL use an arithmetic right shift.
REQ-008 DIV SHALL run restoring division on operand magnitudes, one quotient bit per cycle, 32 cycles, driven by the same counter.
REQ-009 DIV signs SHALL be corrected on transfer to FINISH.
- Quotient is truncated toward zero.
- The remainder takes the sign of the dividend.
REQ-010 Divide overflow case: a=0x80000000, b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no flag.
REQ-011 Latency: a start sampled at edge E0 SHALL leave the unit in MULT or DIV for edges E1..E32, with FINISH entered at edge E32.
- done=1 SHALL hold for exactly the cycle between E32 and E33.
- The unit SHALL return to IDLE at E33.
REQ-012 Divide by zero: a start sampled at E0 SHALL enter FINISH at E1.
- done=1 and div_zero=1 SHALL hold for one cycle.
- hi and lo SHALL keep their previous values.
REQ-013 hi and lo SHALL update only on entry to FINISH and SHALL otherwise hold their last result.
REQ-014 busy SHALL be 1 exactly while in MULT or DIV, and 0 in IDLE and FINISH.
REQ-015 A new start SHALL be accepted no earlier than the IDLE cycle after FINISH; there are no back-to-back starts in FINISH.
REQ-016 The counter SHALL clear on every IDLE-to-MULT and IDLE-to-DIV transition, with no wrap-around carry into the next operation.
REQ-017 Multiply results SHALL be exact 64-bit signed values.
- Example: 0x80000000 * 0x80000000 gives hi=0x40000000, lo=0x00000000.

Reset
REQ-018 When reset=1 at an edge, the unit SHALL set:
- state = IDLE.
- counter = 0.
- hi = lo = 0x00000000.
- busy = done = div_zero = 0.
REQ-019 Reset asserted mid-operation SHALL abort the operation with no done pulse; start inputs are ignored while reset=1.
REQ-020 After reset deasserts, the first edge in IDLE SHALL be able to accept a start.

Verification
REQ-021 Multiply: a=7, b=0xFFFFFFFD (-3), mult_start for one cycle -> after 32 busy cycles, done pulses once with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-022 Divide: a=0xFFFFFFF9 (-7), b=2, div_start -> done at E32+ with lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-023 Divide by zero: first multiply 5*6 (lo=30, hi=0), then div_start with b=0 -> next cycle done=div_zero=1, hi=0 and lo=30 unchanged, busy never 1.
REQ-024 Both starts high with a=3, b=4 -> multiply result lo=12, hi=0; a start pulse at cycle 10 of the operation is ignored and the result is unchanged.
REQ-025 Reset at iteration 15 of a multiply -> no done pulse, hi=lo=0, busy=0; a fresh multiply 0x80000000*0x80000000 then yields hi=0x40000000, lo=0.
REQ-026 Overflow divide: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0, latency 32 cycles.
